// File: rtl/picosoc_iomem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picosoc_iomem_pkg
// Description : Shared types and constants for the PicoSoC iomem router.
//               Holds the transaction state encoding, the read data returned
//               on a failed access, and the width of the port-index field.
// Revision    : 1.0 - initial release
// ============================================================================
package picosoc_iomem_pkg;

  // Width of the port-index field taken from the iomem address.
  localparam int IDX_W = 4;

  // Read data returned to the CPU when an access times out or is unmapped.
  localparam logic [31:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ERR   = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage : picosoc_iomem_pkg
`default_nettype wire

// File: rtl/picosoc_iomem_router.sv
`default_nettype none
// ============================================================================
// Module      : picosoc_iomem_router
// Description : Address-decoding router from the PicoSoC iomem master to up
//               to NUM_PORTS memory-mapped peripherals. One transaction is
//               outstanding at a time. A per-transaction watchdog ends any
//               access a peripheral never acknowledges and records the error.
// Ports       : clk, resetn (async assert, active-low)
//               iomem_valid/wstrb/addr/wdata  - upstream request
//               iomem_ready/rdata             - upstream response (registered)
//               p_valid                       - one-hot downstream request
//               p_wstrb/addr/wdata            - latched request, all ports
//               p_rdata/p_ready               - downstream responses
//               err_pulse_o/count_o/addr_o    - error reporting
// Revision    : 1.0 - initial release
// ============================================================================
module picosoc_iomem_router
  import picosoc_iomem_pkg::*;
#(
  parameter int         NUM_PORTS      = 4,
  parameter logic [7:0] REGION         = 8'h02,
  parameter int         SEL_LSB        = 8,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iomem_valid,
  input  logic [3:0]              iomem_wstrb,
  input  logic [31:0]             iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic                    iomem_ready,
  output logic [31:0]             iomem_rdata,
  output logic [NUM_PORTS-1:0]    p_valid,
  output logic [3:0]              p_wstrb,
  output logic [31:0]             p_addr,
  output logic [31:0]             p_wdata,
  input  logic [NUM_PORTS*32-1:0] p_rdata,
  input  logic [NUM_PORTS-1:0]    p_ready,
  output logic                    err_pulse_o,
  output logic [7:0]              err_count_o,
  output logic [31:0]             err_addr_o
);

  localparam int               c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [IDX_W-1:0]       r_idx;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [NUM_PORTS-1:0]   r_p_valid;
  logic [3:0]             r_wstrb;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic                   r_iomem_ready;
  logic [31:0]            r_iomem_rdata;
  logic                   r_err_pulse;
  logic [7:0]             r_err_count;
  logic [31:0]            r_err_addr;

  logic                   w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_idx_ok;
  logic                   w_timeout;
  logic [NUM_PORTS-1:0]   w_onehot;
  logic                   w_sel_ready;
  logic [31:0]            w_sel_rdata;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_hit     = iomem_valid && (iomem_addr[31:24] == REGION);
  assign w_idx     = iomem_addr[SEL_LSB +: IDX_W];
  assign w_idx_ok  = ({28'd0, w_idx} < NUM_PORTS);
  assign w_timeout = (r_cnt == c_cnt_last);

  // One-hot select for the incoming index, and the response mux for the
  // latched index. Only the latched index is looked at, so a ready from any
  // other port has no effect.
  always_comb begin
    w_onehot    = '0;
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_onehot[i] = (w_idx == IDX_W'(i));
      if (r_idx == IDX_W'(i)) begin
        w_sel_ready = p_ready[i];
        w_sel_rdata = p_rdata[i*32 +: 32];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = w_idx_ok ? ISSUE : ERR;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        // A ready in the final watchdog cycle still completes normally.
        if (w_sel_ready) begin
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_state_nxt = ERR;
        end
      end
      ERR:     w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, watchdog and registered outputs. The upstream-facing and
  // downstream-facing strobes are registered from the next state so that
  // they line up with the state they belong to.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx         <= '0;
      r_cnt         <= '0;
      r_p_valid     <= '0;
      r_wstrb       <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_iomem_ready <= 1'b0;
      r_iomem_rdata <= '0;
      r_err_pulse   <= 1'b0;
      r_err_count   <= '0;
      r_err_addr    <= '0;
    end else begin
      if (r_state == IDLE && w_hit) begin
        r_idx   <= w_idx;
        r_addr  <= iomem_addr;
        r_wstrb <= iomem_wstrb;
        r_wdata <= iomem_wdata;
      end

      if (r_state == WAIT) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else begin
        r_cnt <= '0;
      end

      case (w_state_nxt)
        ISSUE:   r_p_valid <= w_onehot;
        WAIT:    r_p_valid <= r_p_valid;
        default: r_p_valid <= '0;
      endcase

      r_iomem_ready <= (w_state_nxt == RESP);
      if (w_state_nxt == RESP) begin
        if (r_state == WAIT) begin
          r_iomem_rdata <= w_sel_rdata;
        end else begin
          r_iomem_rdata <= (r_wstrb == 4'h0) ? IOMEM_ERR_RDATA : 32'h0;
        end
      end else begin
        r_iomem_rdata <= '0;
      end

      r_err_pulse <= (r_state == ERR);
      if (r_state == ERR) begin
        r_err_addr <= r_addr;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign iomem_ready = r_iomem_ready;
  assign iomem_rdata = r_iomem_rdata;
  assign p_valid     = r_p_valid;
  assign p_wstrb     = r_wstrb;
  assign p_addr      = r_addr;
  assign p_wdata     = r_wdata;
  assign err_pulse_o = r_err_pulse;
  assign err_count_o = r_err_count;
  assign err_addr_o  = r_err_addr;

endmodule : picosoc_iomem_router
`default_nettype wire

// File: tb/tb_picosoc_iomem_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_picosoc_iomem_router
// Description : Self-checking bench for picosoc_iomem_router. Instance 0 uses
//               the default watchdog, instance 1 a short one (8 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picosoc_iomem_router;

  localparam int LIMIT = 400;

  logic         clk;
  logic         resetn;
  logic         valid       [2];
  logic [3:0]   wstrb       [2];
  logic [31:0]  addr        [2];
  logic [31:0]  wdata       [2];
  logic         iomem_ready [2];
  logic [31:0]  iomem_rdata [2];
  logic [3:0]   p_valid     [2];
  logic [3:0]   p_wstrb     [2];
  logic [31:0]  p_addr      [2];
  logic [31:0]  p_wdata     [2];
  logic [127:0] p_rdata     [2];
  logic [3:0]   p_ready     [2];
  logic         err_pulse   [2];
  logic [7:0]   err_count   [2];
  logic [31:0]  err_addr    [2];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err [2];

  picosoc_iomem_router #(
    .NUM_PORTS(4), .REGION(8'h02), .SEL_LSB(8), .TIMEOUT_CYCLES(255)
  ) dut0 (
    .clk(clk), .resetn(resetn),
    .iomem_valid(valid[0]), .iomem_wstrb(wstrb[0]), .iomem_addr(addr[0]),
    .iomem_wdata(wdata[0]), .iomem_ready(iomem_ready[0]), .iomem_rdata(iomem_rdata[0]),
    .p_valid(p_valid[0]), .p_wstrb(p_wstrb[0]), .p_addr(p_addr[0]), .p_wdata(p_wdata[0]),
    .p_rdata(p_rdata[0]), .p_ready(p_ready[0]),
    .err_pulse_o(err_pulse[0]), .err_count_o(err_count[0]), .err_addr_o(err_addr[0])
  );

  picosoc_iomem_router #(
    .NUM_PORTS(4), .REGION(8'h02), .SEL_LSB(8), .TIMEOUT_CYCLES(8)
  ) dut1 (
    .clk(clk), .resetn(resetn),
    .iomem_valid(valid[1]), .iomem_wstrb(wstrb[1]), .iomem_addr(addr[1]),
    .iomem_wdata(wdata[1]), .iomem_ready(iomem_ready[1]), .iomem_rdata(iomem_rdata[1]),
    .p_valid(p_valid[1]), .p_wstrb(p_wstrb[1]), .p_addr(p_addr[1]), .p_wdata(p_wdata[1]),
    .p_rdata(p_rdata[1]), .p_ready(p_ready[1]),
    .err_pulse_o(err_pulse[1]), .err_count_o(err_count[1]), .err_addr_o(err_addr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dly: cycles after p_valid first rises before the peripheral raises ready
  // (0 = combinational ready, -1 = never). Cycle 0 is the request cycle.
  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;
    logic [31:0] rdin;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pv;
    int          exp_pvc;
    int          exp_lat;
    int          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int n, input vec_t v);
    int          d;
    int          idx;
    int          cyc;
    int          first_pv;
    int          pvc;
    int          pulses;
    int          lat;
    int          bad_rdata;
    logic [3:0]  pv_seen;
    logic [31:0] got_rdata;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    d = v.dut;
    idx = int'(v.addr[11:8]);
    @(negedge clk);
    valid[d] = 1'b1;
    addr[d]  = v.addr;
    wdata[d] = v.wdata;
    wstrb[d] = v.wstrb;
    if (idx < 4) p_rdata[d][idx*32 +: 32] = v.rdin;
    cyc = 0; first_pv = -1; pvc = 0; pulses = 0; lat = -1; bad_rdata = 0;
    pv_seen = '0; got_rdata = '0; lat_addr = '0; lat_wdata = '0; lat_wstrb = '0;
    while (lat < 0 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (p_valid[d] != 4'b0) begin
        pvc++;
        pv_seen = pv_seen | p_valid[d];
        if (first_pv < 0) begin
          first_pv  = cyc;
          lat_addr  = p_addr[d];
          lat_wdata = p_wdata[d];
          lat_wstrb = p_wstrb[d];
        end
      end
      if (err_pulse[d]) pulses++;
      if (!iomem_ready[d] && iomem_rdata[d] != 32'h0) bad_rdata++;
      if (iomem_ready[d]) begin
        lat       = cyc;
        got_rdata = iomem_rdata[d];
        valid[d]  = 1'b0;
        p_ready[d] = '0;
      end else if (v.dly >= 0 && first_pv >= 0 && cyc >= first_pv + v.dly && idx < 4) begin
        p_ready[d][idx] = 1'b1;
      end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d_done: got no iomem_ready within %0d cycles, expected one", n, LIMIT);
      valid[d] = 1'b0;
      p_ready[d] = '0;
    end
    // Cycle after RESP: ready must have dropped after exactly one cycle.
    @(negedge clk);
    if (err_pulse[d]) pulses++;
    exp_err[d] += v.exp_err;
    check($sformatf("v%0d_latency", n), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_rdata", n), got_rdata, v.exp_rdata);
    check($sformatf("v%0d_pvalid", n), {28'd0, pv_seen}, {28'd0, v.exp_pv});
    check($sformatf("v%0d_pvalid_cycles", n), 32'(pvc), 32'(v.exp_pvc));
    check($sformatf("v%0d_ready_single", n), {31'd0, iomem_ready[d]}, 32'd0);
    check($sformatf("v%0d_rdata_idle", n), 32'(bad_rdata), 32'd0);
    check($sformatf("v%0d_err_pulses", n), 32'(pulses), 32'(v.exp_err));
    check($sformatf("v%0d_err_count", n), {24'd0, err_count[d]}, 32'(exp_err[d]));
    if (v.exp_pvc > 0) begin
      check($sformatf("v%0d_p_addr", n), lat_addr, v.addr);
      check($sformatf("v%0d_p_wdata", n), lat_wdata, v.wdata);
      check($sformatf("v%0d_p_wstrb", n), {28'd0, lat_wstrb}, {28'd0, v.wstrb});
    end
    if (v.exp_err != 0) begin
      check($sformatf("v%0d_err_addr", n), err_addr[d], v.addr);
    end
  endtask

  initial begin
    int cnt;
    //           dut addr           wdata          wstrb dly rdin           exp_rdata      pv       pvc lat err
    vecs[0] = '{0, 32'h0200_0108, 32'h0000_0001, 4'hF, 1,  32'h0,         32'h0,         4'b0010, 2,  3,  0};
    vecs[1] = '{0, 32'h0200_0204, 32'h0,         4'h0, 0,  32'h0BAD_F00D, 32'h0BAD_F00D, 4'b0100, 2,  3,  0};
    vecs[2] = '{0, 32'h0200_0200, 32'h0,         4'h0, 10, 32'h1234_5678, 32'h1234_5678, 4'b0100, 11, 12, 0};
    vecs[3] = '{0, 32'h0200_0500, 32'h0,         4'h0, -1, 32'h0,         32'hDEAD_BEEF, 4'b0000, 0,  2,  1};
    vecs[4] = '{0, 32'h0200_0F04, 32'hAABB_CCDD, 4'h3, -1, 32'h0,         32'h0,         4'b0000, 0,  2,  1};
    vecs[5] = '{0, 32'h0200_030C, 32'h0,         4'h0, 1,  32'hA5A5_0001, 32'hA5A5_0001, 4'b1000, 2,  3,  0};
    vecs[6] = '{0, 32'h0200_11FC, 32'h0000_5555, 4'hC, 2,  32'h0,         32'h0,         4'b0010, 3,  4,  0};
    vecs[7] = '{1, 32'h0200_0000, 32'h0,         4'h0, -1, 32'h0,         32'hDEAD_BEEF, 4'b0001, 9,  11, 1};
    vecs[8] = '{1, 32'h0200_0000, 32'h0,         4'h0, 8,  32'h0000_0077, 32'h0000_0077, 4'b0001, 9,  10, 0};
    vecs[9] = '{1, 32'h0200_0100, 32'h0000_1234, 4'hF, -1, 32'h0,         32'h0,         4'b0010, 9,  11, 1};

    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; wstrb[d] = '0; addr[d] = '0; wdata[d] = '0;
      p_rdata[d] = '0; p_ready[d] = '0; exp_err[d] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_iomem_ready", {31'd0, iomem_ready[0]}, 32'd0);
    check("rst_iomem_rdata", iomem_rdata[0], 32'd0);
    check("rst_p_valid", {28'd0, p_valid[0]}, 32'd0);
    check("rst_p_addr", p_addr[0], 32'd0);
    check("rst_err_count", {24'd0, err_count[0]}, 32'd0);
    check("rst_err_addr", err_addr[0], 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse[0]}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      run_txn(i, vecs[i]);
    end

    // Late ready after a timeout on instance 1 must be ignored.
    @(negedge clk);
    p_rdata[1][31:0] = 32'h1111_2222;
    p_ready[1] = 4'b0011;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (iomem_ready[1] || p_valid[1] != 4'b0 || err_pulse[1]) cnt++;
    end
    p_ready[1] = '0;
    check("late_ready_ignored", 32'(cnt), 32'd0);
    check("late_ready_err_count", {24'd0, err_count[1]}, 32'(exp_err[1]));

    // Another region: no downstream request and no response for 300 cycles.
    @(negedge clk);
    valid[0] = 1'b1; addr[0] = 32'h0300_0000; wstrb[0] = 4'h0;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (iomem_ready[0] || p_valid[0] != 4'b0) cnt++;
    end
    valid[0] = 1'b0;
    check("other_region_silent", 32'(cnt), 32'd0);

    // Reset asserted while waiting on a peripheral.
    @(negedge clk);
    valid[0] = 1'b1; addr[0] = 32'h0200_0100; wstrb[0] = 4'h0;
    repeat (4) @(negedge clk);
    check("midwait_p_valid", {28'd0, p_valid[0]}, 32'h2);
    #2 resetn = 1'b0;
    #1;
    check("midrst_p_valid", {28'd0, p_valid[0]}, 32'd0);
    check("midrst_iomem_ready", {31'd0, iomem_ready[0]}, 32'd0);
    check("midrst_err_count", {24'd0, err_count[0]}, 32'd0);
    exp_err[0] = 0;
    exp_err[1] = 0;
    valid[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_txn(10, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_picosoc_iomem_router
`default_nettype wire
